avmm_sdram_slave: RTL and testbench



---
 rtl/avmm_sdram_slave_pkg.sv | 18 +
 rtl/avmm_slave_rd_pipe.sv | 37 +++
 rtl/avmm_sdram_slave.sv | 136 +++++++++++++
 tb/tb_avmm_sdram_slave.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/avmm_sdram_slave_pkg.sv
// Shared types and helpers for the Avalon-MM on-chip RAM burst slave.
package avmm_sdram_slave_pkg;

  typedef enum logic [1:0] {IDLE, WR, RD, DRAIN} state_e;

  localparam int DEF_SDRAM_W = 128;
  localparam int BYTES       = DEF_SDRAM_W / 8;
  localparam int OFS         = $clog2(BYTES);

  // Word index relative to the base; wraps in 32 bits so below-base
  // addresses land far out of range instead of aliasing low words.
  function automatic logic [31:0] addr_to_idx(input logic [31:0] addr,
                                              input logic [31:0] base,
                                              input int          ofs);
    return (addr - base) >> ofs;
  endfunction

endpackage

// File: rtl/avmm_slave_rd_pipe.sv
// Fixed-latency read return pipe: LAT stages of {valid, data}, flushable.
module avmm_slave_rd_pipe #(
  parameter int W   = 128,
  parameter int LAT = 2
) (
  input  logic         clk,
  input  logic         flush_i,
  input  logic         vld_i,
  input  logic [W-1:0] data_i,
  output logic         vld_o,
  output logic [W-1:0] data_o,
  output logic         busy_o
);

  logic [LAT-1:0]        vld_q;
  logic [LAT-1:0][W-1:0] data_q;

  // Shift one stage per cycle; flush kills every in-flight beat.
  always_ff @(posedge clk) begin
    if (flush_i) begin
      vld_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q[0]  <= vld_i;
      data_q[0] <= data_i;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign vld_o  = vld_q[LAT-1];
  assign data_o = data_q[LAT-1];
  assign busy_o = |vld_q;

endmodule

// File: rtl/avmm_sdram_slave.sv
// Avalon-MM burst slave on inferred byte-enabled RAM, fixed read latency.
module avmm_sdram_slave
  import avmm_sdram_slave_pkg::*;
#(
  parameter int          SDRAM_W   = DEF_SDRAM_W,
  parameter int          DEPTH     = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          BURST_W   = 11,
  parameter int          RD_LAT    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          address,
  input  logic [BURST_W-1:0]   burstcount,
  input  logic                 read,
  input  logic                 write,
  input  logic [SDRAM_W-1:0]   writedata,
  input  logic [SDRAM_W/8-1:0] byteenable,
  output logic                 waitrequest,
  output logic [SDRAM_W-1:0]   readdata,
  output logic                 readdatavalid,
  output logic                 err
);

  localparam int NB = SDRAM_W / 8;
  localparam int SH = $clog2(NB);
  localparam int IW = $clog2(DEPTH);

  logic [SDRAM_W-1:0] mem [DEPTH];

  state_e             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic               init_q, err_q;

  logic [31:0]        cur_addr, cur_idx;
  logic [BURST_W-1:0] bc_eff;
  logic [SDRAM_W-1:0] rd_word;
  logic               oor, we, issue, err_set, pipe_busy;

  // Beat address: straight from the bus when a command is being accepted,
  // otherwise the running burst address.
  assign cur_addr = (state_q == IDLE) ? address : addr_q;
  assign cur_idx  = addr_to_idx(cur_addr, BASE_ADDR, SH);
  assign oor      = (cur_addr < BASE_ADDR) || (cur_idx >= 32'(DEPTH));
  assign bc_eff   = (burstcount == '0) ? BURST_W'(1) : burstcount;
  assign rd_word  = oor ? '0 : mem[cur_idx[IW-1:0]];

  assign waitrequest = !rst_n || init_q || (state_q == RD) || (state_q == DRAIN);
  assign err         = err_q;

  // Next-state logic. Beat 0 of a read is issued in the accept cycle, so the
  // latched address/count already point at beat 1.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    we      = 1'b0;
    issue   = 1'b0;
    err_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!init_q && (read || write)) begin
          if (burstcount == '0) err_set = 1'b1;
          addr_d = cur_addr + 32'(NB);
          rem_d  = bc_eff - BURST_W'(1);
          if (write) begin
            we = 1'b1;
            if (read) err_set = 1'b1;
            if (bc_eff != BURST_W'(1)) state_d = WR;
          end else begin
            issue   = 1'b1;
            state_d = (bc_eff != BURST_W'(1)) ? RD : DRAIN;
          end
        end
      end
      WR: begin
        if (read) err_set = 1'b1;
        if (write) begin
          we     = 1'b1;
          addr_d = addr_q + 32'(NB);
          rem_d  = rem_q - BURST_W'(1);
          if (rem_q == BURST_W'(1)) state_d = IDLE;
        end
      end
      RD: begin
        issue  = 1'b1;
        addr_d = addr_q + 32'(NB);
        rem_d  = rem_q - BURST_W'(1);
        if (rem_q == BURST_W'(1)) state_d = DRAIN;
      end
      DRAIN: begin
        if (!pipe_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (oor && (we || issue)) err_set = 1'b1;
  end

  // Control registers; err is sticky until reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      init_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      init_q  <= 1'b0;
      if (err_set) err_q <= 1'b1;
    end
  end

  // Byte-enabled RAM write; out-of-range beats and beats under reset drop.
  always_ff @(posedge clk) begin
    if (rst_n && we && !oor) begin
      for (int b = 0; b < NB; b++) begin
        if (byteenable[b]) mem[cur_idx[IW-1:0]][b*8 +: 8] <= writedata[b*8 +: 8];
      end
    end
  end

  avmm_slave_rd_pipe #(.W(SDRAM_W), .LAT(RD_LAT)) u_rd_pipe (
    .clk     (clk),
    .flush_i (!rst_n),
    .vld_i   (issue),
    .data_i  (rd_word),
    .vld_o   (readdatavalid),
    .data_o  (readdata),
    .busy_o  (pipe_busy)
  );

endmodule

// File: tb/tb_avmm_sdram_slave.sv
// Randomized bench for avmm_sdram_slave against a word-array reference model.
module tb_avmm_sdram_slave;

  localparam int          W     = 128;
  localparam int          DEPTH = 4096;
  localparam int          BW    = 11;
  localparam int          LAT   = 2;
  localparam logic [31:0] BASE  = 32'h3000_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   address = '0;
  logic [BW-1:0] burstcount = '0;
  logic          read = 1'b0, write = 1'b0;
  logic [W-1:0]  writedata = '0;
  logic [W/8-1:0] byteenable = '0;
  logic          waitrequest, readdatavalid, err;
  logic [W-1:0]  readdata;

  always #5 clk = ~clk;

  avmm_sdram_slave #(.SDRAM_W(W), .DEPTH(DEPTH), .BASE_ADDR(BASE),
                     .BURST_W(BW), .RD_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .address(address), .burstcount(burstcount),
    .read(read), .write(write), .writedata(writedata), .byteenable(byteenable),
    .waitrequest(waitrequest), .readdata(readdata),
    .readdatavalid(readdatavalid), .err(err)
  );

  int           nchk = 0, nerr = 0;
  bit           exp_err = 1'b0;
  logic [W-1:0] ref_mem [DEPTH];
  logic [W-1:0] wbuf [64];

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic bit is_oor(input logic [31:0] a);
    return (a < BASE) || (((a - BASE) >> 4) >= 32'(DEPTH));
  endfunction

  function automatic void model_wr(input logic [31:0] a, input logic [W-1:0] d, input logic [15:0] be);
    int idx;
    if (is_oor(a)) begin
      exp_err = 1'b1;
      return;
    end
    idx = int'((a - BASE) >> 4);
    for (int b = 0; b < 16; b++)
      if (be[b]) ref_mem[idx][b*8 +: 8] = d[b*8 +: 8];
  endfunction

  function automatic logic [W-1:0] model_rd(input logic [31:0] a);
    if (is_oor(a)) begin
      exp_err = 1'b1;
      return '0;
    end
    return ref_mem[int'((a - BASE) >> 4)];
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 64; i++) begin
      if (!waitrequest) return;
      @(negedge clk);
    end
    chk("idle_wait", waitrequest, 0);
  endtask

  task automatic do_write(input logic [31:0] a, input int bc, input logic [15:0] be,
                          input int stall, input bit rd_too);
    int nb;
    nb = (bc == 0) ? 1 : bc;
    wait_idle();
    write = 1'b1; read = rd_too; address = a; burstcount = BW'(bc);
    byteenable = be; writedata = wbuf[0];
    model_wr(a, wbuf[0], be);
    if (rd_too || bc == 0) exp_err = 1'b1;
    for (int k = 1; k < nb; k++) begin
      @(negedge clk);
      read = 1'b0;
      chk("wr_wait", waitrequest, 0);
      if (k == stall) begin
        write = 1'b0;
        writedata = {4{$urandom}};
        @(negedge clk);
      end
      write = 1'b1; address = $urandom; burstcount = BW'($urandom);
      writedata = wbuf[k];
      model_wr(a + 32'(16 * k), wbuf[k], be);
    end
    @(negedge clk);
    write = 1'b0; read = 1'b0;
    chk("wr_err", err, exp_err);
  endtask

  task automatic do_read(input logic [31:0] a, input int bc);
    int nb, got;
    nb = (bc == 0) ? 1 : bc;
    got = 0;
    wait_idle();
    read = 1'b1; address = a; burstcount = BW'(bc);
    if (bc == 0) exp_err = 1'b1;
    for (int n = 1; n <= nb + LAT + 4; n++) begin
      @(negedge clk);
      if (n == 1) read = 1'b0;
      if (n < LAT + nb) chk("rd_wait", waitrequest, 1);
      if (readdatavalid) begin
        chk("rd_time", n, LAT + got);
        chk("rd_data", readdata, model_rd(a + 32'(16 * got)));
        got++;
      end
    end
    chk("rd_beats", got, nb);
    chk("rd_err", err, exp_err);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int          bc, seen;

    // reset behaviour
    repeat (5) @(negedge clk);
    chk("rst_wait", waitrequest, 1);
    chk("rst_rdv", readdatavalid, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", readdata, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); chk("rel_wait1", waitrequest, 1);
    @(negedge clk); chk("rel_wait2", waitrequest, 0);

    // fill a window so later reads never touch unwritten words
    for (int k = 0; k < 64; k++) wbuf[k] = {4{$urandom}};
    do_write(BASE, 64, 16'hFFFF, -1, 1'b0);

    // 4-beat burst with a stall after beat 1, then read back
    for (int k = 0; k < 4; k++) wbuf[k] = W'(k);
    do_write(BASE, 4, 16'hFFFF, 2, 1'b0);
    do_read(BASE, 4);

    // byteenable merge
    wbuf[0] = '1;
    do_write(BASE + 32'h10, 1, 16'hFFFF, -1, 1'b0);
    wbuf[0] = '0;
    do_write(BASE + 32'h10, 1, 16'h00F0, -1, 1'b0);
    do_read(BASE + 32'h10, 1);

    // random in-range traffic
    for (int it = 0; it < 40; it++) begin
      a = BASE + 32'($urandom_range(0, 56) * 16);
      if ($urandom_range(0, 1) == 1) begin
        bc = $urandom_range(1, 6);
        for (int k = 0; k < bc; k++) wbuf[k] = {4{$urandom}};
        do_write(a, bc, 16'($urandom), $urandom_range(0, bc), 1'b0);
      end else begin
        do_read(a, $urandom_range(1, 8));
      end
    end

    // burst running off the end of the RAM
    a = BASE + 32'((DEPTH - 1) * 16);
    wbuf[0] = {4{$urandom}};
    wbuf[1] = {4{$urandom}};
    do_write(a, 2, 16'hFFFF, -1, 1'b0);
    do_read(a, 2);

    // protocol errors
    wbuf[0] = {4{$urandom}};
    do_write(BASE + 32'h20, 1, 16'hFFFF, -1, 1'b1);
    do_read(BASE, 0);

    // reset in the middle of a read burst
    wait_idle();
    read = 1'b1; address = BASE; burstcount = BW'(8);
    seen = 0;
    for (int n = 1; n <= 40 && seen < 3; n++) begin
      @(negedge clk);
      if (n == 1) read = 1'b0;
      if (readdatavalid) begin
        chk("mid_data", readdata, model_rd(BASE + 32'(16 * seen)));
        seen++;
      end
    end
    chk("mid_seen", seen, 3);
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("mid_rst_rdv", readdatavalid, 0);
      chk("mid_rst_wait", waitrequest, 1);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    exp_err = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("post_rst_rdv", readdatavalid, 0);
    end
    chk("post_rst_err", err, 0);
    chk("post_rst_wait", waitrequest, 0);
    do_read(BASE, 8);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
